dual_pipe_ctrl: RTL and testbench
=================================

// Module: dual_pipe_ctrl
// PURPOSE
//  Central stall/flush sequencer for the dual-issue 5-stage core (IF, ID, EX, Mem, Wb).
//  - Collects stall requests from Icache, Dcache, DecodeHazard and EX, plus branch, exception, WFI and FENCE events.
//  - Drives per-register Ctrl_Stall/Flush vectors into Fetch and the IFID/IDEX/EXMem/MemWb PipeStages.
//  - Tracks per-stage occupancy so WFI and FENCE retire only after downstream stages drain.
// PARAMETERS
//  EXCP_HOLD  1  extra cycles Flush[1:0] stays high after an exception (covers redirect latency)
//  TMO_W      8  width of Dcache-stall watchdog counter
//  TMO_LIMIT  8'd200  consecutive Dcache-stall cycles before Ctrl_StallTmo sets
// PORTS
//  clk                   in   1  core clock
//  rst_n                 in   1  asynchronous active-low reset
//  Icache_StallReq       in   1  fetch data not ready
//  Dcache_StallReq       in   1  Mem-stage access not complete
//  DecodeHazard_StallReq in   1  load-use hazard in ID
//  EX_StallReq           in   1  multi-cycle EX op busy (either slot)
//  EX_BranchFlag_0       in   1  slot-0 redirect taken in EX
//  EX_BranchFlag_1       in   1  slot-1 redirect taken in EX
//  Csr_ExcpFlag          in   1  trap/interrupt taken (1-cycle pulse)
//  Decode_WfiReq         in   1  WFI in ID (either slot)
//  Decode_FenceReq       in   1  FENCE/FENCE.I in ID
//  Csr_WFIClrFlag        in   1  wake event
//  Ctrl_Stall            out  5  [0]PC [1]IFID [2]IDEX [3]EXMem [4]MemWb hold
//  Flush                 out  4  [0]IFID [1]IDEX [2]EXMem [3]MemWb load bubble
//  Ctrl_KillSlot1        out  1  squash slot-1 result in EX (slot-0 redirect)
//  Ctrl_Busy             out  1  state != RUN
//  Ctrl_StallTmo         out  1  sticky watchdog flag, cleared only by reset
// BEHAVIOUR
//  - Reset: all outputs 0, state RUN, stage-valid bits v[3:0]=0, watchdog counter 0.
//  - Ctrl_Stall/Flush/KillSlot1 are combinational from inputs+state (0-cycle latency).
//    State, valids and counter update on posedge clk.
//  - Rule: a held stage holds every upstream stage. The first non-held stage downstream of the hold gets a Flush (bubble).
//  - RUN priority, highest first:
//    1 Csr_ExcpFlag: Stall=0, Flush=4'b1111.
//      If EXCP_HOLD>0 -> EXCP state; else stay RUN.
//    2 Dcache_StallReq: Stall=5'b01111, Flush=4'b1000. Branch flags are ignored; EX is frozen and re-presents them.
//    3 EX_StallReq: Stall=5'b00111, Flush=4'b0100.
//    4 Branch (either flag): Stall=0, Flush=4'b0011.
//      KillSlot1=EX_BranchFlag_0. Slot 0 wins when both flags are set.
//    5 DecodeHazard_StallReq: Stall=5'b00011, Flush=4'b0010.
//    6 Decode_FenceReq or Decode_WfiReq: same as 5.
//      Next state FENCE or WFI_DRAIN (FENCE wins when both are set).
//    7 Icache_StallReq: Stall=5'b00001, Flush=4'b0001.
//  - EXCP: Flush=4'b0011, Stall=0.
//    Down-counter reload EXCP_HOLD; at 0 -> RUN. A new Csr_ExcpFlag reloads the counter.
//  - FENCE / WFI_DRAIN:
//    - Stall=5'b00011, Flush=4'b0010; lower-priority rows 2/3 still apply on top.
//    - When v[3:1]==0 for one cycle: FENCE -> RUN (releases the instruction); WFI_DRAIN -> WFI.
//  - WFI: Stall=5'b00011, Flush=4'b0010. Csr_WFIClrFlag -> RUN next cycle.
//  - Csr_ExcpFlag in any state: forces the row-1 outputs and goes to EXCP; drain is abandoned.
//  - Valid tracking per register i (0=IFID..3=MemWb), evaluated in this order:
//    - Flush[i] -> v[i]=0.
//    - else Stall[i+1] -> hold.
//    - else v[i] = v[i-1]; v[-1]=1 unless Stall[0].
//  - Watchdog:
//    - Counter increments while Dcache_StallReq, saturating at all-ones; clears when Dcache_StallReq drops.
//    - Ctrl_StallTmo sets when counter==TMO_LIMIT.
//  - Reset asserted mid-drain or mid-WFI returns to RUN immediately; no pending event survives.
// STRUCTURE
//  - Define.v: `CTRL_ST_RUN/EXCP/FENCE/WFI_DRAIN/WFI (3-bit) and `CTRL_STALL_W=5, `CTRL_FLUSH_W=4.
//  - Sub-module ctrl_stage_valid: 4-bit occupancy tracker; inputs Stall/Flush, output v[3:0].
//  - Top holds the FSM, the EXCP counter, the watchdog and the priority mux.
// TESTING
//  - Icache+DecodeHazard together -> Stall=00011, Flush=0010.
//    Dcache added same cycle -> Stall=01111, Flush=1000.
//  - EX_BranchFlag_0=EX_BranchFlag_1=1 -> Flush=0011, KillSlot1=1.
//    With Dcache_StallReq=1 -> no flush; branch takes effect in the cycle after the stall drops.
//  - Csr_ExcpFlag pulse with EXCP_HOLD=1:
//    - cycle0 Flush=1111
//    - cycle1 Flush=0011, Busy=1
//    - cycle2 RUN, Busy=0.
//  - FENCE with 3 instrs in flight:
//    - Busy for 3 cycles; Stall[1:0]=11 throughout.
//    - Release on the first cycle with v[3:1]==0; exact release cycle checked against the model.
//  - WFI: drain -> WFI state, Stall=00011 for 50 cycles.
//    Csr_WFIClrFlag -> Stall=0 next cycle. Csr_ExcpFlag during WFI -> EXCP.
//  - Dcache_StallReq held 201 cycles (TMO_LIMIT=200) -> Ctrl_StallTmo rises at cycle 200 and stays set.
//    rst_n low mid-WFI -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/dual_pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dual_pipe_ctrl_pkg
// Description : Shared state encoding and stall/flush vectors for the
//               dual-issue pipeline stall/flush sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package dual_pipe_ctrl_pkg;

  localparam int CTRL_STALL_W = 5;
  localparam int CTRL_FLUSH_W = 4;

  typedef enum logic [2:0] {
    CTRL_ST_RUN       = 3'd0,
    CTRL_ST_EXCP      = 3'd1,
    CTRL_ST_FENCE     = 3'd2,
    CTRL_ST_WFI_DRAIN = 3'd3,
    CTRL_ST_WFI       = 3'd4
  } ctrl_state_e;

  // Stall vector: [0]PC [1]IFID [2]IDEX [3]EXMem [4]MemWb
  localparam logic [CTRL_STALL_W-1:0] C_STALL_NONE   = 5'b00000;
  localparam logic [CTRL_STALL_W-1:0] C_STALL_DCACHE = 5'b01111;
  localparam logic [CTRL_STALL_W-1:0] C_STALL_EX     = 5'b00111;
  localparam logic [CTRL_STALL_W-1:0] C_STALL_ID     = 5'b00011;
  localparam logic [CTRL_STALL_W-1:0] C_STALL_IF     = 5'b00001;

  // Flush vector: [0]IFID [1]IDEX [2]EXMem [3]MemWb
  localparam logic [CTRL_FLUSH_W-1:0] C_FLUSH_NONE   = 4'b0000;
  localparam logic [CTRL_FLUSH_W-1:0] C_FLUSH_ALL    = 4'b1111;
  localparam logic [CTRL_FLUSH_W-1:0] C_FLUSH_DCACHE = 4'b1000;
  localparam logic [CTRL_FLUSH_W-1:0] C_FLUSH_EX     = 4'b0100;
  localparam logic [CTRL_FLUSH_W-1:0] C_FLUSH_BRANCH = 4'b0011;
  localparam logic [CTRL_FLUSH_W-1:0] C_FLUSH_ID     = 4'b0010;
  localparam logic [CTRL_FLUSH_W-1:0] C_FLUSH_IF     = 4'b0001;

endpackage
`default_nettype wire

// File: rtl/ctrl_stage_valid.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_stage_valid
// Description : Occupancy tracker for the four pipeline registers
//               (0=IFID .. 3=MemWb), driven by the same stall/flush
//               vectors the sequencer sends to the pipe stages.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_stage_valid
  import dual_pipe_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CTRL_STALL_W-1:0] stall,
  input  logic [CTRL_FLUSH_W-1:0] flush,
  output logic [CTRL_FLUSH_W-1:0] v
);

  // Value each register loads when it advances; fetch feeds a valid
  // instruction whenever the PC is not held.
  logic [CTRL_FLUSH_W-1:0] w_feed;
  assign w_feed = {v[CTRL_FLUSH_W-2:0], ~stall[0]};

  // Flush wins over hold; a register held by its own stall bit keeps its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
    end else begin
      for (int i = 0; i < CTRL_FLUSH_W; i++) begin
        if (flush[i]) begin
          v[i] <= 1'b0;
        end else if (!stall[i+1]) begin
          v[i] <= w_feed[i];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dual_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dual_pipe_ctrl
// Description : Central stall/flush sequencer for the dual-issue 5-stage
//               core. Priority-muxes stall requests and redirect events into
//               per-register stall/flush vectors, drains the pipe for FENCE
//               and WFI, and watches for runaway Dcache stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module dual_pipe_ctrl
  import dual_pipe_ctrl_pkg::*;
#(
  parameter int          EXCP_HOLD = 1,
  parameter int          TMO_W     = 8,
  parameter int unsigned TMO_LIMIT = 200
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    Icache_StallReq,
  input  logic                    Dcache_StallReq,
  input  logic                    DecodeHazard_StallReq,
  input  logic                    EX_StallReq,
  input  logic                    EX_BranchFlag_0,
  input  logic                    EX_BranchFlag_1,
  input  logic                    Csr_ExcpFlag,
  input  logic                    Decode_WfiReq,
  input  logic                    Decode_FenceReq,
  input  logic                    Csr_WFIClrFlag,
  output logic [CTRL_STALL_W-1:0] Ctrl_Stall,
  output logic [CTRL_FLUSH_W-1:0] Flush,
  output logic                    Ctrl_KillSlot1,
  output logic                    Ctrl_Busy,
  output logic                    Ctrl_StallTmo
);

  // The hold counter stores cycles remaining minus one, so EXCP lasts
  // exactly EXCP_HOLD cycles after the trap cycle.
  localparam int EXCP_CW = (EXCP_HOLD > 1) ? $clog2(EXCP_HOLD) : 1;
  localparam logic [EXCP_CW-1:0] C_EXCP_RELOAD =
      (EXCP_HOLD > 0) ? EXCP_CW'(EXCP_HOLD - 1) : '0;
  localparam ctrl_state_e C_EXCP_ENTRY = (EXCP_HOLD > 0) ? CTRL_ST_EXCP : CTRL_ST_RUN;

  ctrl_state_e             r_state;
  ctrl_state_e             w_state_nxt;
  logic [EXCP_CW-1:0]      r_excp_cnt;
  logic [TMO_W-1:0]        r_wd_cnt;
  logic                    r_tmo;
  logic [CTRL_FLUSH_W-1:0] w_v;
  logic                    w_drained;
  logic                    w_run_blocked;
  logic                    w_tmo_hit;

  assign w_drained     = (w_v[3:1] == 3'b000);
  assign w_run_blocked = Dcache_StallReq | EX_StallReq | EX_BranchFlag_0 |
                         EX_BranchFlag_1 | DecodeHazard_StallReq;
  assign w_tmo_hit     = (r_wd_cnt == TMO_W'(TMO_LIMIT));

  // Priority mux: trap first, then state-specific rows, 0-cycle latency.
  always_comb begin
    Ctrl_Stall     = C_STALL_NONE;
    Flush          = C_FLUSH_NONE;
    Ctrl_KillSlot1 = 1'b0;
    if (Csr_ExcpFlag) begin
      Flush = C_FLUSH_ALL;
    end else begin
      case (r_state)
        CTRL_ST_RUN: begin
          if (Dcache_StallReq) begin
            // EX is frozen, so any pending branch is re-presented later.
            Ctrl_Stall = C_STALL_DCACHE;
            Flush      = C_FLUSH_DCACHE;
          end else if (EX_StallReq) begin
            Ctrl_Stall = C_STALL_EX;
            Flush      = C_FLUSH_EX;
          end else if (EX_BranchFlag_0 | EX_BranchFlag_1) begin
            Flush          = C_FLUSH_BRANCH;
            Ctrl_KillSlot1 = EX_BranchFlag_0;
          end else if (DecodeHazard_StallReq | Decode_FenceReq | Decode_WfiReq) begin
            Ctrl_Stall = C_STALL_ID;
            Flush      = C_FLUSH_ID;
          end else if (Icache_StallReq) begin
            Ctrl_Stall = C_STALL_IF;
            Flush      = C_FLUSH_IF;
          end
        end
        CTRL_ST_EXCP: begin
          Flush = C_FLUSH_BRANCH;
        end
        CTRL_ST_FENCE, CTRL_ST_WFI_DRAIN: begin
          // Older instructions still draining may stall in Mem or EX.
          if (Dcache_StallReq) begin
            Ctrl_Stall = C_STALL_DCACHE;
            Flush      = C_FLUSH_DCACHE;
          end else if (EX_StallReq) begin
            Ctrl_Stall = C_STALL_EX;
            Flush      = C_FLUSH_EX;
          end else begin
            Ctrl_Stall = C_STALL_ID;
            Flush      = C_FLUSH_ID;
          end
        end
        CTRL_ST_WFI: begin
          Ctrl_Stall = C_STALL_ID;
          Flush      = C_FLUSH_ID;
        end
        default: begin
          Ctrl_Stall = C_STALL_NONE;
        end
      endcase
    end
  end

  // Next-state selection; a trap overrides any drain in progress.
  always_comb begin
    w_state_nxt = r_state;
    if (Csr_ExcpFlag) begin
      w_state_nxt = C_EXCP_ENTRY;
    end else begin
      case (r_state)
        CTRL_ST_RUN: begin
          if (!w_run_blocked) begin
            if (Decode_FenceReq) begin
              w_state_nxt = CTRL_ST_FENCE;
            end else if (Decode_WfiReq) begin
              w_state_nxt = CTRL_ST_WFI_DRAIN;
            end
          end
        end
        CTRL_ST_EXCP:      if (r_excp_cnt == '0) w_state_nxt = CTRL_ST_RUN;
        CTRL_ST_FENCE:     if (w_drained) w_state_nxt = CTRL_ST_RUN;
        CTRL_ST_WFI_DRAIN: if (w_drained) w_state_nxt = CTRL_ST_WFI;
        CTRL_ST_WFI:       if (Csr_WFIClrFlag) w_state_nxt = CTRL_ST_RUN;
        default:           w_state_nxt = CTRL_ST_RUN;
      endcase
    end
  end

  // FSM register with registered busy flag and trap hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= CTRL_ST_RUN;
      Ctrl_Busy  <= 1'b0;
      r_excp_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      Ctrl_Busy <= (w_state_nxt != CTRL_ST_RUN);
      if (Csr_ExcpFlag) begin
        r_excp_cnt <= C_EXCP_RELOAD;
      end else if ((r_state == CTRL_ST_EXCP) && (r_excp_cnt != '0)) begin
        r_excp_cnt <= r_excp_cnt - 1'b1;
      end
    end
  end

  // Dcache watchdog: saturating run-length counter plus sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt <= '0;
      r_tmo    <= 1'b0;
    end else begin
      if (!Dcache_StallReq) begin
        r_wd_cnt <= '0;
      end else if (r_wd_cnt != '1) begin
        r_wd_cnt <= r_wd_cnt + 1'b1;
      end
      if (w_tmo_hit) begin
        r_tmo <= 1'b1;
      end
    end
  end

  // The flag is visible in the same cycle the count reaches the limit.
  assign Ctrl_StallTmo = r_tmo | w_tmo_hit;

  ctrl_stage_valid u_stage_valid (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (Ctrl_Stall),
    .flush (Flush),
    .v     (w_v)
  );

endmodule
`default_nettype wire

// File: tb/tb_dual_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dual_pipe_ctrl
// Description : Self-checking bench for dual_pipe_ctrl with a queue of
//               expected output vectors and a small occupancy model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dual_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       Icache_StallReq = 1'b0, Dcache_StallReq = 1'b0;
  logic       DecodeHazard_StallReq = 1'b0, EX_StallReq = 1'b0;
  logic       EX_BranchFlag_0 = 1'b0, EX_BranchFlag_1 = 1'b0;
  logic       Csr_ExcpFlag = 1'b0, Decode_WfiReq = 1'b0;
  logic       Decode_FenceReq = 1'b0, Csr_WFIClrFlag = 1'b0;
  logic [4:0] Ctrl_Stall;
  logic [3:0] Flush;
  logic       Ctrl_KillSlot1, Ctrl_Busy, Ctrl_StallTmo;

  dual_pipe_ctrl dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .Icache_StallReq       (Icache_StallReq),
    .Dcache_StallReq       (Dcache_StallReq),
    .DecodeHazard_StallReq (DecodeHazard_StallReq),
    .EX_StallReq           (EX_StallReq),
    .EX_BranchFlag_0       (EX_BranchFlag_0),
    .EX_BranchFlag_1       (EX_BranchFlag_1),
    .Csr_ExcpFlag          (Csr_ExcpFlag),
    .Decode_WfiReq         (Decode_WfiReq),
    .Decode_FenceReq       (Decode_FenceReq),
    .Csr_WFIClrFlag        (Csr_WFIClrFlag),
    .Ctrl_Stall            (Ctrl_Stall),
    .Flush                 (Flush),
    .Ctrl_KillSlot1        (Ctrl_KillSlot1),
    .Ctrl_Busy             (Ctrl_Busy),
    .Ctrl_StallTmo         (Ctrl_StallTmo)
  );

  always #5 clk = ~clk;

  // Input bit positions in the packed stimulus word
  localparam logic [9:0] IN_NONE = 10'b0000000000;
  localparam logic [9:0] IN_IC   = 10'b0000000001;
  localparam logic [9:0] IN_DC   = 10'b0000000010;
  localparam logic [9:0] IN_HZ   = 10'b0000000100;
  localparam logic [9:0] IN_EX   = 10'b0000001000;
  localparam logic [9:0] IN_B0   = 10'b0000010000;
  localparam logic [9:0] IN_B1   = 10'b0000100000;
  localparam logic [9:0] IN_XC   = 10'b0001000000;
  localparam logic [9:0] IN_WFI  = 10'b0010000000;
  localparam logic [9:0] IN_FN   = 10'b0100000000;
  localparam logic [9:0] IN_CLR  = 10'b1000000000;

  localparam logic [4:0] S_0  = 5'b00000;
  localparam logic [4:0] S_ID = 5'b00011;
  localparam logic [3:0] F_0  = 4'b0000;
  localparam logic [3:0] F_ID = 4'b0010;

  typedef struct packed {
    logic [4:0] stall;
    logic [3:0] flush;
    logic       kill;
    logic       busy;
    logic       tmo;
  } exp_t;

  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         step_no = 0;
  logic       exp_tmo = 1'b0;
  logic [3:0] mdl_v   = 4'b0000;
  logic [4:0] prev_st = 5'b00000;
  logic [3:0] prev_fl = 4'b0000;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", tag, step_no, got, exp);
    end
  endtask

  // Advance the occupancy model by one clock using last cycle's vectors.
  task automatic model_edge();
    logic [3:0] feed;
    logic [3:0] nv;
    feed = {mdl_v[2:0], ~prev_st[0]};
    for (int i = 0; i < 4; i++) begin
      if (prev_fl[i])         nv[i] = 1'b0;
      else if (prev_st[i+1])  nv[i] = mdl_v[i];
      else                    nv[i] = feed[i];
    end
    mdl_v = nv;
  endtask

  // One clock: drive inputs after the edge, queue the expectation,
  // then compare on the falling edge.
  task automatic step(input logic [9:0] in, input logic [4:0] st, input logic [3:0] fl,
                      input logic kl, input logic bz);
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    step_no++;
    {Csr_WFIClrFlag, Decode_FenceReq, Decode_WfiReq, Csr_ExcpFlag, EX_BranchFlag_1,
     EX_BranchFlag_0, EX_StallReq, DecodeHazard_StallReq, Dcache_StallReq,
     Icache_StallReq} = in;
    e.stall = st; e.flush = fl; e.kill = kl; e.busy = bz; e.tmo = exp_tmo;
    sb.push_back(e);
    prev_st = st;
    prev_fl = fl;
    @(negedge clk);
    e = sb.pop_front();
    check_eq("stall", 32'(Ctrl_Stall), 32'(e.stall));
    check_eq("flush", 32'(Flush), 32'(e.flush));
    check_eq("kill",  32'(Ctrl_KillSlot1), 32'(e.kill));
    check_eq("busy",  32'(Ctrl_Busy), 32'(e.busy));
    check_eq("tmo",   32'(Ctrl_StallTmo), 32'(e.tmo));
  endtask

  // Drain cycles of FENCE/WFI_DRAIN until the model shows v[3:1] empty.
  task automatic drain(output int n);
    n = 0;
    do begin
      step(IN_NONE, S_ID, F_ID, 1'b0, 1'b1);
      n++;
    end while ((mdl_v[3:1] != 3'b000) && (n < 10));
  endtask

  task automatic reset_model();
    mdl_v = 4'b0000; prev_st = 5'b00000; prev_fl = 4'b0000; exp_tmo = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout step %0d: got running expected finished", step_no);
    $fatal(1);
  end

  initial begin
    int n;
    // Reset state
    #12;
    check_eq("rst_stall", 32'(Ctrl_Stall), 32'd0);
    check_eq("rst_flush", 32'(Flush), 32'd0);
    check_eq("rst_busy",  32'(Ctrl_Busy), 32'd0);
    check_eq("rst_tmo",   32'(Ctrl_StallTmo), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();

    repeat (4) step(IN_NONE, S_0, F_0, 1'b0, 1'b0);

    // Combined requests resolve by priority
    step(IN_IC | IN_HZ,         S_ID,     F_ID,    1'b0, 1'b0);
    step(IN_IC | IN_HZ | IN_DC, 5'b01111, 4'b1000, 1'b0, 1'b0);
    step(IN_B0 | IN_B1,         S_0,      4'b0011, 1'b1, 1'b0);
    // Branch held behind a Dcache stall takes effect once it drops
    repeat (3) step(IN_B0 | IN_B1 | IN_DC, 5'b01111, 4'b1000, 1'b0, 1'b0);
    step(IN_B0 | IN_B1, S_0, 4'b0011, 1'b1, 1'b0);
    step(IN_B1,         S_0, 4'b0011, 1'b0, 1'b0);
    step(IN_EX | IN_HZ, 5'b00111, 4'b0100, 1'b0, 1'b0);
    step(IN_IC,         5'b00001, 4'b0001, 1'b0, 1'b0);

    // Trap with one hold cycle
    step(IN_XC,   S_0, 4'b1111, 1'b0, 1'b0);
    step(IN_NONE, S_0, 4'b0011, 1'b0, 1'b1);
    repeat (4) step(IN_NONE, S_0, F_0, 1'b0, 1'b0);

    // FENCE with the pipe full behind it
    step(IN_FN, S_ID, F_ID, 1'b0, 1'b0);
    drain(n);
    check_eq("fence_len", 32'(n), 32'd3);
    step(IN_NONE, S_0, F_0, 1'b0, 1'b0);
    repeat (3) step(IN_NONE, S_0, F_0, 1'b0, 1'b0);

    // WFI: drain, sleep, wake
    step(IN_WFI, S_ID, F_ID, 1'b0, 1'b0);
    drain(n);
    repeat (50) step(IN_NONE, S_ID, F_ID, 1'b0, 1'b1);
    step(IN_CLR,  S_ID, F_ID, 1'b0, 1'b1);
    step(IN_NONE, S_0,  F_0,  1'b0, 1'b0);

    // Trap while asleep
    step(IN_WFI, S_ID, F_ID, 1'b0, 1'b0);
    drain(n);
    repeat (3) step(IN_NONE, S_ID, F_ID, 1'b0, 1'b1);
    step(IN_XC,   S_0, 4'b1111, 1'b0, 1'b1);
    step(IN_NONE, S_0, 4'b0011, 1'b0, 1'b1);
    step(IN_NONE, S_0, F_0,     1'b0, 1'b0);

    // Watchdog: 201 consecutive Dcache-stall cycles
    for (int k = 0; k <= 200; k++) begin
      if (k == 200) exp_tmo = 1'b1;
      step(IN_DC, 5'b01111, 4'b1000, 1'b0, 1'b0);
    end
    repeat (2) step(IN_NONE, S_0, F_0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of WFI
    step(IN_WFI, S_ID, F_ID, 1'b0, 1'b0);
    drain(n);
    repeat (3) step(IN_NONE, S_ID, F_ID, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_stall", 32'(Ctrl_Stall), 32'd0);
    check_eq("arst_flush", 32'(Flush), 32'd0);
    check_eq("arst_busy",  32'(Ctrl_Busy), 32'd0);
    check_eq("arst_tmo",   32'(Ctrl_StallTmo), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    repeat (2) step(IN_NONE, S_0, F_0, 1'b0, 1'b0);

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
